// File: rtl/accel_sample_fifo_if.sv
// Sample-path bus between the capture side / host and accel_sample_fifo.
// master drives triplets and pops; slave (the FIFO) returns the head entry.
interface accel_sample_fifo_if #(
    parameter int DATA_W = 16,
    parameter int SEQ_W  = 16
);
    logic              data_interrupt;
    logic [DATA_W-1:0] x_data;
    logic [DATA_W-1:0] y_data;
    logic [DATA_W-1:0] z_data;
    logic              rd_en;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_x;
    logic [DATA_W-1:0] rd_y;
    logic [DATA_W-1:0] rd_z;
    logic [SEQ_W-1:0]  rd_seq;

    modport master (
        output data_interrupt, x_data, y_data, z_data, rd_en,
        input  rd_valid, rd_x, rd_y, rd_z, rd_seq
    );

    modport slave (
        input  data_interrupt, x_data, y_data, z_data, rd_en,
        output rd_valid, rd_x, rd_y, rd_z, rd_seq
    );
endinterface

// File: rtl/accel_sample_fifo.sv
// First-word-fall-through FIFO of sequence-tagged x/y/z accelerometer triplets,
// with fill level, saturating drop counter and level-threshold interrupt.
module accel_sample_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int SEQ_W  = 16
) (
    input  logic                     sys_clk,
    input  logic                     reset_n,
    accel_sample_fifo_if.slave       bus,
    input  logic                     clear,
    input  logic [$clog2(DEPTH):0]   irq_threshold,
    output logic [$clog2(DEPTH):0]   level,
    output logic [SEQ_W-1:0]         overflow_count,
    output logic                     irq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] z;
        logic [SEQ_W-1:0]  seq;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY, S_NONEMPTY, S_FULL} state_t;

    state_t            state, state_nxt;
    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [SEQ_W-1:0]  seq;
    logic [LVL_W-1:0]  level_nxt;
    logic              push, pop, do_write, do_pop, drop, irq_nxt;

    assign push = bus.data_interrupt;
    assign pop  = bus.rd_en && bus.rd_valid;

    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        do_write  = 1'b0;
        do_pop    = 1'b0;
        drop      = 1'b0;
        level_nxt = level;
        state_nxt = state;
        if (clear) begin
            level_nxt = '0;
        end else begin
            // A push into a full FIFO still lands when the head is popped this cycle.
            do_write = push && (state != S_FULL || pop);
            do_pop   = pop;
            drop     = push && state == S_FULL && !pop;
            if (do_write && !do_pop)      level_nxt = level + 1'b1;
            else if (!do_write && do_pop) level_nxt = level - 1'b1;
        end
        if (level_nxt == '0)            state_nxt = S_EMPTY;
        else if (level_nxt == FULL_LVL) state_nxt = S_FULL;
        else                            state_nxt = S_NONEMPTY;
        irq_nxt = (irq_threshold != '0) && (level_nxt >= irq_threshold);
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples the
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_EMPTY;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            seq            <= '0;
            overflow_count <= '0;
            irq            <= 1'b0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            irq   <= irq_nxt;
            if (push) seq <= seq + 1'b1;
            if (clear) begin
                wr_ptr         <= '0;
                rd_ptr         <= '0;
                overflow_count <= '0;
            end else begin
                if (do_write) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)   rd_ptr <= rd_ptr + 1'b1;
                if (drop && overflow_count != '1)
                    overflow_count <= overflow_count + 1'b1;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; rd_valid masks stale
    // contents, and leaving it out lets the array map onto plain RAM.
    always_ff @(posedge sys_clk) begin
        if (do_write)
            mem[wr_ptr] <= '{x: bus.x_data, y: bus.y_data, z: bus.z_data, seq: seq};
    end

    assign bus.rd_valid = (state != S_EMPTY);
    assign bus.rd_x     = mem[rd_ptr].x;
    assign bus.rd_y     = mem[rd_ptr].y;
    assign bus.rd_z     = mem[rd_ptr].z;
    assign bus.rd_seq   = mem[rd_ptr].seq;
endmodule
